// File: rtl/btn_irq_pkg.sv
// btn_irq_pkg: register map constants and vector encoding shared by the button interrupt controller.
package btn_irq_pkg;
    localparam int DATA_W = 8;
    localparam int VEC_VALID_BIT = 7;
    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_ENABLE  = 2'd2;
    localparam logic [1:0] ADDR_VECTOR  = 2'd3;
    // Lowest-numbered active bit wins, so press bits outrank release bits.
    function automatic logic [DATA_W-1:0] vec_of(input logic [DATA_W-1:0] pe);
        vec_of = '0;
        for (int i = DATA_W - 1; i >= 0; i--)
            if (pe[i]) vec_of = DATA_W'(i) | (DATA_W'(1) << VEC_VALID_BIT);
    endfunction
endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect: per-bit rise/fall pulses, suppressed until one level sample exists after reset.
module btn_edge_detect #(
    parameter int N = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);
    logic [N-1:0] prev;
    logic         armed;
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev  <= '0;
            armed <= 1'b0;
        end else begin
            prev  <= level;
            armed <= 1'b1;
        end
    end
    assign rise = armed ? level & ~prev : '0;
    assign fall = armed ? ~level & prev : '0;
endmodule

// File: rtl/button_irq_ctrl.sv
// button_irq_ctrl: sticky press-event pending bits, enable mask, level irq and register port.
// Define BTN_IRQ_RELEASE_EN to also latch release events in bits [N_BTN+3:4].
module button_irq_ctrl
    import btn_irq_pkg::*;
#(
    parameter int N_BTN = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_BTN-1:0]  btn_level,
    input  logic              cs,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              irq
);
    localparam logic [DATA_W-1:0] BTN_MASK = DATA_W'((1 << N_BTN) - 1);
`ifdef BTN_IRQ_RELEASE_EN
    localparam logic [DATA_W-1:0] IMPL_MASK = BTN_MASK | (BTN_MASK << 4);
`else
    localparam logic [DATA_W-1:0] IMPL_MASK = BTN_MASK;
`endif
    logic [N_BTN-1:0]  rise, fall;
    logic [DATA_W-1:0] pending, enable, ev, clr, rd_mux;
    logic              acc, wr;
    btn_edge_detect #(.N(N_BTN)) u_edge (
        .CLK   (CLK),
        .RST   (RST),
        .level (btn_level),
        .rise  (rise),
        .fall  (fall)
    );
    always_comb begin
        acc    = cs & ~ack;
        wr     = acc & we;
        ev     = (DATA_W'(rise) | (DATA_W'(fall) << 4)) & IMPL_MASK;
        clr    = (wr && addr == ADDR_PENDING) ? wdata : '0;
        rd_mux = addr == ADDR_STATUS  ? DATA_W'(btn_level) :
                 addr == ADDR_PENDING ? pending :
                 addr == ADDR_ENABLE  ? enable : vec_of(pending & enable);
    end
    // Events are OR-ed in after the clear so a same-cycle set always survives.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending <= '0;
            enable  <= '0;
            irq     <= 1'b0;
            ack     <= 1'b0;
            rdata   <= '0;
        end else begin
            pending <= (pending & ~clr) | ev;
            enable  <= (wr && addr == ADDR_ENABLE) ? wdata & IMPL_MASK : enable;
            irq     <= |(pending & enable);
            ack     <= acc;
            rdata   <= (acc && !we) ? rd_mux : '0;
        end
    end
endmodule

// File: tb/tb_button_irq_ctrl.sv
// tb_button_irq_ctrl: directed self-checking bench for button_irq_ctrl.
module tb_button_irq_ctrl;
    logic       CLK = 1'b0, RST = 1'b1, cs = 1'b0, we = 1'b0, ack, irq;
    logic [3:0] btn_level = 4'b0001;
    logic [1:0] addr = 2'd0;
    logic [7:0] wdata = 8'h00, rdata, d;
    logic       irq_at_ack;
    int         checks = 0, failures = 0;

    button_irq_ctrl #(.N_BTN(4)) dut (
        .CLK(CLK), .RST(RST), .btn_level(btn_level), .cs(cs), .we(we),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .irq(irq)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        cs = 1'b1; we = 1'b0; addr = a;
        tick();
        chk("rd_ack", {7'd0, ack}, 8'h01);
        v = rdata;
        cs = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] v);
        cs = 1'b1; we = 1'b1; addr = a; wdata = v;
        tick();
        chk("wr_ack", {7'd0, ack}, 8'h01);
        irq_at_ack = irq;
        cs = 1'b0; we = 1'b0;
        tick();
    endtask

    task automatic release_all();
        btn_level = 4'b0000;
        tick();
        wr(2'd1, 8'hFF);
    endtask

    initial begin
        // Reset with button 0 held: no event may appear.
        repeat (3) tick();
        chk("rst_ack", {7'd0, ack}, 8'h00);
        chk("rst_irq", {7'd0, irq}, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        RST = 1'b0;
        wr(2'd2, 8'h01);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("held_irq", {7'd0, irq}, 8'h00);
        end
        rd(2'd1, d); chk("held_pend", d, 8'h00);
        rd(2'd0, d); chk("status", d, 8'h01);
        chk("idle_rdata", rdata, 8'h00);
        release_all();

        // Single press of button 2.
        wr(2'd2, 8'h05);
        btn_level = 4'b0100;
        tick();
        chk("t2_irq_T", {7'd0, irq}, 8'h00);
        rd(2'd1, d); chk("t2_pend", d, 8'h04);
        chk("t2_irq", {7'd0, irq}, 8'h01);
        rd(2'd3, d); chk("t2_vec", d, 8'h82);
        wr(2'd1, 8'h04);
        chk("t2_irq_clr", {7'd0, irq}, 8'h00);
        release_all();

        // Buttons 0 and 2 together, cleared one at a time.
        btn_level = 4'b0101;
        tick();
        rd(2'd3, d); chk("t3_vec0", d, 8'h80);
        wr(2'd1, 8'h01);
        rd(2'd3, d); chk("t3_vec2", d, 8'h82);
        chk("t3_irq_hold", {7'd0, irq}, 8'h01);
        wr(2'd1, 8'h04);
        chk("t3_irq_at_ack", {7'd0, irq_at_ack}, 8'h01);
        chk("t3_irq_clr", {7'd0, irq}, 8'h00);
        release_all();

        // Set and W1C on the same bit in the same cycle.
        cs = 1'b1; we = 1'b1; addr = 2'd1; wdata = 8'h02; btn_level = 4'b0010;
        tick();
        cs = 1'b0; we = 1'b0;
        tick();
        rd(2'd1, d); chk("t4_set_wins", d, 8'h02);
        wr(2'd1, 8'h02);
        rd(2'd1, d); chk("t4_cleared", d, 8'h00);
        release_all();

        // Disabled button still latches; enabling raises irq.
        wr(2'd2, 8'h00);
        btn_level = 4'b1000;
        tick();
        tick();
        rd(2'd1, d); chk("t5_pend", d, 8'h08);
        chk("t5_irq_off", {7'd0, irq}, 8'h00);
        wr(2'd2, 8'h08);
        chk("t5_irq_at_ack", {7'd0, irq_at_ack}, 8'h00);
        chk("t5_irq_on", {7'd0, irq}, 8'h01);
        rd(2'd3, d); chk("t5_vec", d, 8'h83);
        wr(2'd0, 8'hFF);
        rd(2'd0, d); chk("t5_status_ro", d, 8'h08);
        wr(2'd2, 8'hFF);
        rd(2'd2, d);
`ifdef BTN_IRQ_RELEASE_EN
        chk("t5_enable_mask", d, 8'hFF);
`else
        chk("t5_enable_mask", d, 8'h0F);
`endif
        release_all();
        rd(2'd1, d); chk("t5_pend_clr", d, 8'h00);

        // Press and release of button 0 with only the release bit enabled.
        wr(2'd2, 8'h10);
        btn_level = 4'b0001;
        tick();
        btn_level = 4'b0000;
        tick();
        tick();
        rd(2'd1, d);
`ifdef BTN_IRQ_RELEASE_EN
        chk("t6_pend", d, 8'h11);
        rd(2'd3, d); chk("t6_vec", d, 8'h84);
        chk("t6_irq", {7'd0, irq}, 8'h01);
`else
        chk("t6_pend", d, 8'h01);
        rd(2'd3, d); chk("t6_vec", d, 8'h00);
        chk("t6_irq", {7'd0, irq}, 8'h00);
`endif

        // Reset in the accept cycle discards the access.
        cs = 1'b1; we = 1'b1; addr = 2'd2; wdata = 8'h01; RST = 1'b1;
        tick();
        chk("rst_mid_ack", {7'd0, ack}, 8'h00);
        cs = 1'b0; we = 1'b0; RST = 1'b0;
        tick();
        rd(2'd2, d); chk("rst_mid_en", d, 8'h00);
        rd(2'd1, d); chk("rst_mid_pend", d, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
